// File: rtl/bsg_manycore_npa_req_launcher.sv
// Remote-request launcher: buffers translated requests in a 2-entry FIFO toward the
// network link, gated by an outstanding-credit count, and drops invalid-address requests.
module bsg_manycore_npa_req_launcher #(
    parameter int x_cord_width_p    = 7,
    parameter int y_cord_width_p    = 7,
    parameter int addr_width_p      = 28,
    parameter int data_width_p      = 32,
    parameter int max_out_credits_p = 16,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [x_cord_width_p-1:0]   x_cord_i,
    input  logic [y_cord_width_p-1:0]   y_cord_i,
    input  logic [addr_width_p-1:0]     epa_i,
    input  logic                        is_invalid_addr_i,
    input  logic [data_width_p-1:0]     data_i,
    input  logic [data_width_p/8-1:0]   mask_i,
    input  logic [1:0]                  op_i,
    input  logic [4:0]                  reg_id_i,

    output logic                        link_v_o,
    input  logic                        link_ready_i,
    output logic [x_cord_width_p-1:0]   link_x_o,
    output logic [y_cord_width_p-1:0]   link_y_o,
    output logic [addr_width_p-1:0]     link_epa_o,
    output logic [data_width_p-1:0]     link_data_o,
    output logic [data_width_p/8-1:0]   link_mask_o,
    output logic [1:0]                  link_op_o,
    output logic [4:0]                  link_reg_id_o,

    input  logic                        credit_return_i,
    output logic [credit_width_lp-1:0]  out_credits_o,
    output logic                        credits_full_o,

    output logic                        invalid_addr_err_o,
    output logic [1:0]                  err_op_o,
    output logic [4:0]                  err_reg_id_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    logic [x_cord_width_p-1:0]  x_mem     [2];
    logic [y_cord_width_p-1:0]  y_mem     [2];
    logic [addr_width_p-1:0]    epa_mem   [2];
    logic [data_width_p-1:0]    data_mem  [2];
    logic [data_width_p/8-1:0]  mask_mem  [2];
    logic [1:0]                 op_mem    [2];
    logic [4:0]                 reg_mem   [2];

    logic wr_ptr_r, rd_ptr_r, full_r;
    logic empty;
    logic accept, bad_req, enq, deq;
    logic [credit_width_lp-1:0] credits_r, credits_n;

    assign empty   = (wr_ptr_r == rd_ptr_r) && !full_r;
    assign ready_o = !full_r && (credits_r != '0);

    // op 3 is reserved and handled exactly like a translator invalid-address flag
    assign bad_req = is_invalid_addr_i || (op_i == 2'd3);
    assign accept  = v_i && ready_o;
    assign enq     = accept && !bad_req;
    assign deq     = link_v_o && link_ready_i;

    assign link_v_o      = !empty;
    assign link_x_o      = x_mem[rd_ptr_r];
    assign link_y_o      = y_mem[rd_ptr_r];
    assign link_epa_o    = epa_mem[rd_ptr_r];
    assign link_data_o   = data_mem[rd_ptr_r];
    assign link_mask_o   = mask_mem[rd_ptr_r];
    assign link_op_o     = op_mem[rd_ptr_r];
    assign link_reg_id_o = reg_mem[rd_ptr_r];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            x_mem[wr_ptr_r]    <= x_cord_i;
            y_mem[wr_ptr_r]    <= y_cord_i;
            epa_mem[wr_ptr_r]  <= epa_i;
            data_mem[wr_ptr_r] <= data_i;
            mask_mem[wr_ptr_r] <= mask_i;
            op_mem[wr_ptr_r]   <= op_i;
            reg_mem[wr_ptr_r]  <= reg_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (enq) wr_ptr_r <= ~wr_ptr_r;
            if (deq) rd_ptr_r <= ~rd_ptr_r;
            if (enq && !deq)
                full_r <= (~wr_ptr_r == rd_ptr_r);
            else if (deq && !enq)
                full_r <= 1'b0;
        end
    end

    // Returns at the maximum saturate rather than wrap
    always_comb begin
        credits_n = credits_r;
        if (enq && !credit_return_i)
            credits_n = credits_r - 1'b1;
        else if (!enq && credit_return_i && (credits_r != max_credits_lp))
            credits_n = credits_r + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) credits_r <= max_credits_lp;
        else          credits_r <= credits_n;
    end

    assign out_credits_o  = credits_r;
    assign credits_full_o = (credits_r == max_credits_lp);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            invalid_addr_err_o <= 1'b0;
            err_op_o           <= '0;
            err_reg_id_o       <= '0;
        end else if (accept && bad_req && !invalid_addr_err_o) begin
            invalid_addr_err_o <= 1'b1;
            err_op_o           <= op_i;
            err_reg_id_o       <= reg_id_i;
        end
    end

    credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(credit_return_i && !enq && credits_full_o));

endmodule

// File: tb/tb_bsg_manycore_npa_req_launcher.sv
// Directed bench for the request launcher: handshake, FIFO ordering, credits,
// invalid-request capture and asynchronous reset.
module tb_bsg_manycore_npa_req_launcher;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [6:0]  x_cord_i, y_cord_i;
    logic [27:0] epa_i;
    logic        is_invalid_addr_i;
    logic [31:0] data_i;
    logic [3:0]  mask_i;
    logic [1:0]  op_i;
    logic [4:0]  reg_id_i;
    logic        link_v_o, link_ready_i;
    logic [6:0]  link_x_o, link_y_o;
    logic [27:0] link_epa_o;
    logic [31:0] link_data_o;
    logic [3:0]  link_mask_o;
    logic [1:0]  link_op_o;
    logic [4:0]  link_reg_id_o;
    logic        credit_return_i;
    logic [4:0]  out_credits_o;
    logic        credits_full_o;
    logic        invalid_addr_err_o;
    logic [1:0]  err_op_o;
    logic [4:0]  err_reg_id_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    bsg_manycore_npa_req_launcher #(
        .x_cord_width_p(7), .y_cord_width_p(7), .addr_width_p(28),
        .data_width_p(32), .max_out_credits_p(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_i(v_i), .ready_o(ready_o),
        .x_cord_i(x_cord_i), .y_cord_i(y_cord_i), .epa_i(epa_i),
        .is_invalid_addr_i(is_invalid_addr_i), .data_i(data_i), .mask_i(mask_i),
        .op_i(op_i), .reg_id_i(reg_id_i),
        .link_v_o(link_v_o), .link_ready_i(link_ready_i),
        .link_x_o(link_x_o), .link_y_o(link_y_o), .link_epa_o(link_epa_o),
        .link_data_o(link_data_o), .link_mask_o(link_mask_o), .link_op_o(link_op_o),
        .link_reg_id_o(link_reg_id_o),
        .credit_return_i(credit_return_i), .out_credits_o(out_credits_o),
        .credits_full_o(credits_full_o),
        .invalid_addr_err_o(invalid_addr_err_o), .err_op_o(err_op_o),
        .err_reg_id_o(err_reg_id_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic [6:0] x, input logic [1:0] op,
                           input logic inv, input logic [4:0] rid);
        v_i = v; x_cord_i = x; op_i = op; is_invalid_addr_i = inv; reg_id_i = rid;
    endtask

    initial begin
        reset_i = 1'b0; link_ready_i = 1'b0; credit_return_i = 1'b0;
        set_req(1'b0, 7'd0, 2'd0, 1'b0, 5'd0);
        y_cord_i = '0; epa_i = '0; data_i = '0; mask_i = '0;
        repeat (2) @(negedge clk_i);

        chk("rst_link_v", link_v_o, 0);
        chk("rst_credits", out_credits_o, 16);
        chk("rst_full", credits_full_o, 1);
        chk("rst_err", invalid_addr_err_o, 0);
        chk("rst_err_op", err_op_o, 0);
        chk("rst_err_reg", err_reg_id_o, 0);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", ready_o, 1);

        // single request, 1-cycle latency
        set_req(1'b1, 7'd3, 2'd1, 1'b0, 5'd4);
        y_cord_i = 7'd2; epa_i = 28'h40; data_i = 32'hDEADBEEF; mask_i = 4'hF;
        link_ready_i = 1'b1;
        #1 chk("t1_no_bypass", link_v_o, 0);
        @(negedge clk_i);
        v_i = 1'b0;
        chk("t1_link_v", link_v_o, 1);
        chk("t1_x", link_x_o, 3);
        chk("t1_y", link_y_o, 2);
        chk("t1_epa", link_epa_o, 28'h40);
        chk("t1_data", link_data_o, 32'hDEADBEEF);
        chk("t1_op", link_op_o, 1);
        chk("t1_reg", link_reg_id_o, 4);
        chk("t1_credits", out_credits_o, 15);
        @(negedge clk_i);
        chk("t1_drained", link_v_o, 0);
        credit_return_i = 1'b1;
        @(negedge clk_i);
        credit_return_i = 1'b0;
        chk("t1_ret_credits", out_credits_o, 16);

        // back-pressure: three requests, FIFO holds two
        link_ready_i = 1'b0;
        set_req(1'b1, 7'd1, 2'd1, 1'b0, 5'd1);
        @(negedge clk_i);
        chk("bp_ready_1", ready_o, 1);
        set_req(1'b1, 7'd2, 2'd1, 1'b0, 5'd2);
        @(negedge clk_i);
        chk("bp_ready_full", ready_o, 0);
        chk("bp_head_a", link_x_o, 1);
        chk("bp_credits_2", out_credits_o, 14);
        set_req(1'b1, 7'd3, 2'd1, 1'b0, 5'd3);
        @(negedge clk_i);
        chk("bp_ready_held", ready_o, 0);
        chk("bp_head_stable", link_x_o, 1);
        chk("bp_head_reg", link_reg_id_o, 1);
        link_ready_i = 1'b1;
        @(negedge clk_i);
        link_ready_i = 1'b0;
        chk("bp_head_b", link_x_o, 2);
        chk("bp_ready_after_deq", ready_o, 1);
        chk("bp_credits_no_c", out_credits_o, 14);
        @(negedge clk_i);
        v_i = 1'b0;
        chk("bp_c_accepted", out_credits_o, 13);
        chk("bp_full_again", ready_o, 0);
        link_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_head_c", link_x_o, 3);
        chk("bp_head_c_reg", link_reg_id_o, 3);
        @(negedge clk_i);
        chk("bp_empty", link_v_o, 0);
        credit_return_i = 1'b1;
        repeat (3) @(negedge clk_i);
        credit_return_i = 1'b0;
        chk("bp_credits_back", out_credits_o, 16);

        // credit exhaustion
        set_req(1'b1, 7'd5, 2'd0, 1'b0, 5'd5);
        repeat (16) @(negedge clk_i);
        v_i = 1'b0;
        chk("ex_credits_0", out_credits_o, 0);
        chk("ex_ready_0", ready_o, 0);
        credit_return_i = 1'b1;
        #1 chk("ex_ready_not_comb", ready_o, 0);
        @(negedge clk_i);
        credit_return_i = 1'b0;
        chk("ex_ready_back", ready_o, 1);
        chk("ex_credits_1", out_credits_o, 1);
        credit_return_i = 1'b1;
        repeat (4) @(negedge clk_i);
        credit_return_i = 1'b0;
        chk("ex_credits_5", out_credits_o, 5);

        // simultaneous accept and return
        v_i = 1'b1; credit_return_i = 1'b1;
        @(negedge clk_i);
        v_i = 1'b0; credit_return_i = 1'b0;
        chk("sim_credits", out_credits_o, 5);
        chk("sim_full", credits_full_o, 0);
        credit_return_i = 1'b1;
        repeat (11) @(negedge clk_i);
        credit_return_i = 1'b0;
        chk("sim_restore", out_credits_o, 16);
        chk("sim_restore_full", credits_full_o, 1);

        // invalid requests: first captured, later ones ignored, op 3 also invalid
        set_req(1'b1, 7'd6, 2'd2, 1'b1, 5'd7);
        @(negedge clk_i);
        chk("inv1_err", invalid_addr_err_o, 1);
        chk("inv1_op", err_op_o, 2);
        chk("inv1_reg", err_reg_id_o, 7);
        set_req(1'b1, 7'd6, 2'd0, 1'b1, 5'd9);
        @(negedge clk_i);
        set_req(1'b1, 7'd6, 2'd3, 1'b0, 5'd11);
        @(negedge clk_i);
        v_i = 1'b0;
        chk("inv_link_v", link_v_o, 0);
        chk("inv_credits", out_credits_o, 16);
        chk("inv_err", invalid_addr_err_o, 1);
        chk("inv_keep_op", err_op_o, 2);
        chk("inv_keep_reg", err_reg_id_o, 7);

        // asynchronous reset with two queued
        link_ready_i = 1'b0;
        set_req(1'b1, 7'd8, 2'd1, 1'b0, 5'd8);
        repeat (2) @(negedge clk_i);
        v_i = 1'b0;
        chk("ar_queued", link_v_o, 1);
        chk("ar_credits_pre", out_credits_o, 14);
        #2 reset_i = 1'b0;
        #1;
        chk("ar_link_v", link_v_o, 0);
        chk("ar_credits", out_credits_o, 16);
        chk("ar_err", invalid_addr_err_o, 0);
        chk("ar_err_op", err_op_o, 0);
        chk("ar_ready", ready_o, 1);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("ar_post_link_v", link_v_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
